spi_txn_arbiter: RTL
====================

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2: cycles of cs_n low before the first byte.
REQ-002 SHALL have parameter CS_HOLD, default 2: cycles of cs_n low after the last byte.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for spi_rx_dv per byte.
REQ-004 Port clk, input, 1: sole clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port req_valid, input, 2: per-requester transaction request.
REQ-007 Ports req_len0 and req_len1, input, 4 each: byte count per requester; 0 is treated as 1.
REQ-008 Ports req_tx_byte0 and req_tx_byte1, input, 8 each: current byte to send per requester.
REQ-009 Port req_byte_take, output, 2: one-cycle pulse when the granted requester's tx byte is consumed.
REQ-010 Port rsp_rx_valid, output, 2: one-cycle pulse marking rsp_rx_byte valid for that requester.
REQ-011 Port rsp_rx_byte, output, 8: received byte, shared by both requesters.
REQ-012 Port done, output, 2: one-cycle pulse on successful transaction end.
REQ-013 Port err, output, 2: one-cycle pulse on timeout abort.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port cs_n, output, 2: active-low chip select per requester's device.
REQ-016 Port spi_tx_byte, output, 8: byte to the SPI controller.
REQ-017 Port spi_tx_dv, output, 1: tx byte valid strobe to the SPI controller.
REQ-018 Port spi_tx_ready, input, 1: SPI controller ready for a new byte.
REQ-019 Port spi_rx_dv, input, 1: SPI controller rx byte valid strobe.
REQ-020 Port spi_rx_byte, input, 8: received byte from the SPI controller.

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, SEND, WAIT_RX, HOLD.
REQ-022 SHALL sample req_valid only in IDLE; any req_valid high moves to SETUP next cycle, latching grant g and len (0 becomes 1).
REQ-023 SHALL arbitrate round-robin: a single requester wins; if both request, the one not last granted wins; last_grant resets to 1, so requester 0 wins the first tie.
REQ-024 SHALL drive cs_n[g] low from SETUP entry through the end of HOLD; cs_n[!g] stays high; both are high in IDLE.
REQ-025 SETUP SHALL last exactly CS_SETUP cycles, then enter SEND.
REQ-026 In SEND, in the first cycle with spi_tx_ready=1, SHALL drive spi_tx_dv=1 and spi_tx_byte=req_tx_byte[g], pulse req_byte_take[g] in the same cycle, then enter WAIT_RX.
REQ-027 spi_tx_dv SHALL be high for exactly one cycle per byte and never while spi_tx_ready=0.
REQ-028 WAIT_RX SHALL, on spi_rx_dv=1: register rsp_rx_byte<=spi_rx_byte, pulse rsp_rx_valid[g] the next cycle, and decrement remaining; if remaining becomes 0, enter HOLD, else enter SEND.
REQ-029 SHALL clear the timeout counter on WAIT_RX entry; if the counter reaches TIMEOUT_CYC-1 without spi_rx_dv, SHALL set an abort flag and enter HOLD.
REQ-030 spi_rx_dv arriving in the same cycle as the timeout limit SHALL count as a received byte, not a timeout.
REQ-031 HOLD SHALL last CS_HOLD cycles, then release cs_n and return to IDLE, pulsing done[g] (or err[g] if aborted, never both) on the IDLE entry cycle.
REQ-032 SHALL keep at least one IDLE cycle between transactions, with cs_n all high.
REQ-033 req_valid deassertion mid-transaction SHALL be ignored; spi_rx_dv outside WAIT_RX SHALL be ignored.
REQ-034 SHALL use a 4-bit remaining counter and a timeout counter of width clog2(TIMEOUT_CYC); neither counter wraps.

Reset
REQ-035 While reset=1, SHALL be in IDLE with cs_n=2'b11, all pulses 0, spi_tx_dv=0, busy=0, rsp_rx_byte=0, spi_tx_byte=0, last_grant=1.
REQ-036 Reset asserted mid-transaction SHALL abort immediately, releasing cs_n asynchronously, with no done or err pulse.

Verification
REQ-037 Test single request: req_valid=01, len0=3, controller echoing ready/rx_dv -> 3 take pulses, 3 rsp_rx_valid[0] pulses, cs_n[0] low for 2+3 bytes+2 cycles, then one done[0].
REQ-038 Test tie: req_valid=11 held for two transactions -> grant order 0 then 1; cs_n[1] stays high throughout transaction 0.
REQ-039 Test timeout: spi_rx_dv never asserted -> err[g] pulse after 1024 WAIT_RX cycles plus CS_HOLD; no done; next request is served.
REQ-040 Test len0=0 -> exactly one byte transferred.
REQ-041 Test spi_tx_ready held low 50 cycles in SEND -> no spi_tx_dv until ready rises, then exactly one pulse.
REQ-042 Test reset mid-WAIT_RX -> cs_n=11 and busy=0 immediately; no done or err pulse.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter giving one of two requesters a chip-selected SPI transaction of 1..15 bytes.
// Byte handshake with an external SPI controller; a per-byte rx timeout aborts through HOLD and reports err.
module spi_txn_arbiter #(
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [3:0] req_len0,
  input  logic [3:0] req_len1,
  input  logic [7:0] req_tx_byte0,
  input  logic [7:0] req_tx_byte1,
  output logic [1:0] req_byte_take,
  output logic [1:0] rsp_rx_valid,
  output logic [7:0] rsp_rx_byte,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       busy,
  output logic [1:0] cs_n,
  output logic [7:0] spi_tx_byte,
  output logic       spi_tx_dv,
  input  logic       spi_tx_ready,
  input  logic       spi_rx_dv,
  input  logic [7:0] spi_rx_byte
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int PW = 8;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT_RX, S_HOLD} state_t;

  state_t        r_state, w_next;
  logic          r_g, r_last_grant, r_abort;
  logic [3:0]    r_rem;
  logic [PW-1:0] r_ph;
  logic [TW-1:0] r_to;
  logic [7:0]    r_rx_byte;
  logic [1:0]    r_rx_vld, r_done, r_err;
  logic          w_grant, w_tx_fire, w_setup_end, w_hold_end, w_to_end;
  logic [1:0]    w_gmask;

  // On a tie the requester that was not granted last wins.
  assign w_grant     = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_gmask     = r_g ? 2'b10 : 2'b01;
  assign w_tx_fire   = (r_state == S_SEND) && spi_tx_ready;
  assign w_setup_end = (r_ph == PW'(CS_SETUP - 1));
  assign w_hold_end  = (r_ph == PW'(CS_HOLD - 1));
  assign w_to_end    = (r_to == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req_valid) w_next = S_SETUP;
      S_SETUP:   if (w_setup_end) w_next = S_SEND;
      S_SEND:    if (spi_tx_ready) w_next = S_WAIT_RX;
      S_WAIT_RX: begin
        if (spi_rx_dv)     w_next = (r_rem == 4'd1) ? S_HOLD : S_SEND;
        else if (w_to_end) w_next = S_HOLD;
      end
      S_HOLD:    if (w_hold_end) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_g          <= 1'b0;
      r_last_grant <= 1'b1;
      r_abort      <= 1'b0;
      r_rem        <= 4'd0;
      r_ph         <= '0;
      r_to         <= '0;
      r_rx_byte    <= 8'h00;
      r_rx_vld     <= 2'b00;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
    end else begin
      r_rx_vld <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_g          <= w_grant;
          r_last_grant <= w_grant;
          r_abort      <= 1'b0;
          r_ph         <= '0;
          if (w_grant) r_rem <= (req_len1 == 4'd0) ? 4'd1 : req_len1;
          else         r_rem <= (req_len0 == 4'd0) ? 4'd1 : req_len0;
        end
        S_SETUP: r_ph <= w_setup_end ? '0 : r_ph + 1'b1;
        S_SEND:  r_to <= '0;
        S_WAIT_RX: begin
          // A byte landing on the final timeout cycle still counts as received.
          if (spi_rx_dv) begin
            r_rx_byte <= spi_rx_byte;
            r_rx_vld  <= w_gmask;
            r_rem     <= r_rem - 1'b1;
          end else if (w_to_end) begin
            r_abort <= 1'b1;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_HOLD: begin
          r_ph <= w_hold_end ? '0 : r_ph + 1'b1;
          if (w_hold_end) begin
            r_done <= r_abort ? 2'b00 : w_gmask;
            r_err  <= r_abort ? w_gmask : 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    cs_n          = (r_state != S_IDLE) ? ~w_gmask : 2'b11;
    spi_tx_dv     = w_tx_fire;
    spi_tx_byte   = 8'h00;
    req_byte_take = 2'b00;
    if (w_tx_fire) begin
      spi_tx_byte   = r_g ? req_tx_byte1 : req_tx_byte0;
      req_byte_take = w_gmask;
    end
  end

  assign rsp_rx_valid = r_rx_vld;
  assign rsp_rx_byte  = r_rx_byte;
  assign done         = r_done;
  assign err          = r_err;

endmodule
